// File: rtl/register_file_pkg.sv
// Shared core constants for the integer register file.
//   XLEN       : GPR width in bits
//   REG_ADDR_W : GPR index width
//   NUM_GPRS   : number of GPRs (2**REG_ADDR_W)
//   ZERO_REG   : index of the hardwired-zero register x0
package register_file_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_GPRS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Register-file access bus between the pipeline (master) and the register file (slave).
//   ReadRegister1/2 : ID-stage read indices (rs1, rs2)
//   WriteRegister   : WB-stage write index (rd)
//   WriteData       : WB-stage write data
//   WriteEnable     : WB-stage write strobe
//   ReadData1/2     : read results, combinational in the same cycle
interface register_file_if;
    import register_file_pkg::*;

    logic [REG_ADDR_W-1:0]  ReadRegister1;
    logic [REG_ADDR_W-1:0]  ReadRegister2;
    logic [REG_ADDR_W-1:0]  WriteRegister;
    logic [XLEN-1:0]        WriteData;
    logic                   WriteEnable;
    logic signed [XLEN-1:0] ReadData1;
    logic signed [XLEN-1:0] ReadData2;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, WriteEnable,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, WriteEnable,
        output ReadData1, ReadData2
    );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read path of the register file.
//   rst         : forces the result to zero while asserted
//   readIdx     : register index being read
//   regValue    : stored contents of regs[readIdx]
//   writeEnable : WB write strobe (for bypass)
//   writeIdx    : WB write index (for bypass)
//   writeData   : WB write data (for bypass)
//   readData    : resulting read value
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] readIdx,
    input  logic [DATA_WIDTH-1:0] regValue,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeIdx,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZERO_REG);

    logic bypassHit;

    // A write to x0 is discarded, so it must never be forwarded either.
    assign bypassHit = writeEnable && (writeIdx != ZeroIdx) && (writeIdx == readIdx);

    always_comb begin
        readData = '0;
        if (rst || readIdx == ZeroIdx) begin
            readData = '0;
        end else if (bypassHit) begin
            readData = writeData;
        end else begin
            readData = regValue;
        end
    end

endmodule

// File: rtl/register_file.sv
// RISC-V integer register file: 32 x 64-bit GPRs, two read ports, one write port.
// Reads are combinational with write-through bypass from the WB write port;
// x0 reads as zero and ignores writes.
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset, clears all registers and forces reads to 0
//   bus : register_file_if slave modport (read indices, write port, read data)
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned NUM_REGS   = NUM_GPRS
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ZeroIdx = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    // Reset takes priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WriteEnable && bus.WriteRegister != ZeroIdx) begin
            regs[bus.WriteRegister] <= bus.WriteData;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_readPort1 (
        .rst         (rst),
        .readIdx     (bus.ReadRegister1),
        .regValue    (regs[bus.ReadRegister1]),
        .writeEnable (bus.WriteEnable),
        .writeIdx    (bus.WriteRegister),
        .writeData   (bus.WriteData),
        .readData    (readData1)
    );

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_readPort2 (
        .rst         (rst),
        .readIdx     (bus.ReadRegister2),
        .regValue    (regs[bus.ReadRegister2]),
        .writeEnable (bus.WriteEnable),
        .writeIdx    (bus.WriteRegister),
        .writeData   (bus.WriteData),
        .readData    (readData2)
    );

    assign bus.ReadData1 = readData1;
    assign bus.ReadData2 = readData2;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    import register_file_pkg::*;

    logic clk;
    logic rst;
    int   errCount;
    int   checkCount;

    register_file_if rfIf ();

    register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (rfIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", tag, $signed(observed),
                     observed, $signed(expected), expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setWrite(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] data);
        rfIf.WriteEnable   = we;
        rfIf.WriteRegister = rd;
        rfIf.WriteData     = data;
    endtask

    task automatic setRead(input logic [4:0] rs1, input logic [4:0] rs2);
        rfIf.ReadRegister1 = rs1;
        rfIf.ReadRegister2 = rs2;
        #1;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst        = 1'b1;
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd1, 5'd2);

        // Reads are forced to zero while reset is held, even before the clearing edge.
        checkValue("rst_force_rd1", rfIf.ReadData1, 64'd0);
        checkValue("rst_force_rd2", rfIf.ReadData2, 64'd0);
        tick();
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            setRead(5'(i), 5'(32 - i));
            checkValue($sformatf("reset_x%0d_rd1", i), rfIf.ReadData1, 64'd0);
            checkValue($sformatf("reset_x%0d_rd2", i), rfIf.ReadData2, 64'd0);
        end

        // Basic write then read.
        setWrite(1'b1, 5'd1, 64'd42);
        tick();
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd1, 5'd0);
        checkValue("wr_x1_rd1", rfIf.ReadData1, 64'd42);
        checkValue("wr_x0_rd2", rfIf.ReadData2, 64'd0);

        // Negative value, stored bit-exact.
        setWrite(1'b1, 5'd2, -64'sd15);
        tick();
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd1, 5'd2);
        checkValue("neg_x1_rd1", rfIf.ReadData1, 64'd42);
        checkValue("neg_x2_rd2", rfIf.ReadData2, 64'hFFFF_FFFF_FFFF_FFF1);

        // x0 ignores writes and is never bypassed.
        setWrite(1'b1, 5'd0, 64'd100);
        setRead(5'd0, 5'd0);
        checkValue("x0_no_bypass", rfIf.ReadData1, 64'd0);
        tick();
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd0, 5'd1);
        checkValue("x0_protect", rfIf.ReadData1, 64'd0);
        checkValue("x0_protect_x1", rfIf.ReadData2, 64'd42);

        // WriteEnable low: no bypass and no store.
        setWrite(1'b0, 5'd3, 64'd99);
        setRead(5'd3, 5'd3);
        checkValue("we0_no_bypass", rfIf.ReadData1, 64'd0);
        tick();
        setRead(5'd3, 5'd2);
        checkValue("we0_no_store", rfIf.ReadData1, 64'd0);
        checkValue("we0_x2_kept", rfIf.ReadData2, 64'hFFFF_FFFF_FFFF_FFF1);

        // Bypass on both ports, other index unaffected.
        setWrite(1'b1, 5'd5, 64'd7);
        setRead(5'd5, 5'd4);
        checkValue("bypass_rd1", rfIf.ReadData1, 64'd7);
        checkValue("bypass_other_rd2", rfIf.ReadData2, 64'd0);
        setRead(5'd1, 5'd5);
        checkValue("bypass_rd2", rfIf.ReadData2, 64'd7);
        checkValue("bypass_other_rd1", rfIf.ReadData1, 64'd42);
        tick();
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd5, 5'd5);
        checkValue("stored_x5_rd1", rfIf.ReadData1, 64'd7);
        checkValue("stored_x5_rd2", rfIf.ReadData2, 64'd7);

        // Top index, extreme bit pattern; overwrite of an existing register.
        setWrite(1'b1, 5'd31, 64'h8000_0000_0000_0001);
        tick();
        setWrite(1'b1, 5'd1, 64'h0123_4567_89AB_CDEF);
        tick();
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd31, 5'd1);
        checkValue("x31_pattern", rfIf.ReadData1, 64'h8000_0000_0000_0001);
        checkValue("x1_overwrite", rfIf.ReadData2, 64'h0123_4567_89AB_CDEF);

        // Reset mid-operation dominates a simultaneous write and a bypass hit.
        rst = 1'b1;
        setWrite(1'b1, 5'd6, 64'd9);
        setRead(5'd6, 5'd31);
        checkValue("rst_blocks_bypass", rfIf.ReadData1, 64'd0);
        checkValue("rst_force_x31", rfIf.ReadData2, 64'd0);
        tick();
        rst = 1'b0;
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd6, 5'd31);
        checkValue("rst_prio_x6", rfIf.ReadData1, 64'd0);
        checkValue("rst_clear_x31", rfIf.ReadData2, 64'd0);
        setRead(5'd1, 5'd5);
        checkValue("rst_clear_x1", rfIf.ReadData1, 64'd0);
        checkValue("rst_clear_x5", rfIf.ReadData2, 64'd0);

        // Writes behave normally after reset.
        setWrite(1'b1, 5'd6, 64'd123);
        tick();
        setWrite(1'b0, 5'd0, '0);
        setRead(5'd6, 5'd2);
        checkValue("post_rst_x6", rfIf.ReadData1, 64'd123);
        checkValue("post_rst_x2", rfIf.ReadData2, 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
